// File: rtl/cordic_pkg.sv
// Shared widths, angle constants and FSM state type for the CORDIC vectoring engine.
package cordic_pkg;

  localparam int unsigned ITER = 18;
  localparam int unsigned DW   = 18;
  localparam int unsigned IW   = 20;
  localparam int unsigned AW   = 19;

  localparam logic signed [AW-1:0] PI_HALF = 19'sd102944;
  localparam logic signed [AW-1:0] PI      = 19'sd205887;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan(2^-idx) in Q2.16 radians.
module cordic_atan_rom (
  input  logic [4:0]  idx,
  output logic [17:0] atan
);

  always_comb begin
    atan = '0;
    case (idx)
      5'd0:    atan = 18'd51471;
      5'd1:    atan = 18'd30386;
      5'd2:    atan = 18'd16055;
      5'd3:    atan = 18'd8149;
      5'd4:    atan = 18'd4090;
      5'd5:    atan = 18'd2046;
      5'd6:    atan = 18'd1024;
      5'd7:    atan = 18'd512;
      5'd8:    atan = 18'd256;
      5'd9:    atan = 18'd128;
      5'd10:   atan = 18'd64;
      5'd11:   atan = 18'd32;
      5'd12:   atan = 18'd16;
      5'd13:   atan = 18'd8;
      5'd14:   atan = 18'd4;
      5'd15:   atan = 18'd2;
      5'd16:   atan = 18'd1;
      default: atan = 18'd0;
    endcase
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: (x, y) -> (K*|v|, atan2(y, x)), one micro-rotation per clock.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] mag_out,
  output logic [AW-1:0] angle_out
);

  state_e               state_q;
  logic signed [IW-1:0] x_q, y_q;
  logic signed [AW-1:0] z_q;
  logic [4:0]           iter_q;
  logic                 zero_q;

  logic [4:0]           rom_idx;
  logic [17:0]          atan_val;
  logic signed [AW-1:0] atan_ext;
  logic signed [IW-1:0] x_sh, y_sh, x_nx, y_nx, x_ext, y_ext;
  logic signed [AW-1:0] z_nx;
  logic                 d;

  // The table is only addressed while iterating; index parks at 0 otherwise.
  assign rom_idx = (state_q == StIter) ? iter_q : 5'd0;

  cordic_atan_rom u_atan_rom (
    .idx  (rom_idx),
    .atan (atan_val)
  );

  assign atan_ext = {1'b0, atan_val};
  assign x_ext    = {{(IW-DW){x_in[DW-1]}}, x_in};
  assign y_ext    = {{(IW-DW){y_in[DW-1]}}, y_in};

  always_comb begin
    d    = ~y_q[IW-1];
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (d) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_ext;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      zero_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            iter_q   <= '0;
            zero_q   <= (x_in == '0) && (y_in == '0);
            in_ready <= 1'b0;
            state_q  <= StIter;
            // Fold the left half-plane onto the right so the iterations converge.
            if (!x_ext[IW-1]) begin
              x_q <= x_ext;
              y_q <= y_ext;
              z_q <= '0;
            end else if (!y_ext[IW-1]) begin
              x_q <= y_ext;
              y_q <= -x_ext;
              z_q <= PI_HALF;
            end else begin
              x_q <= -y_ext;
              y_q <= x_ext;
              z_q <= -PI_HALF;
            end
          end
        end
        StIter: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          z_q    <= z_nx;
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'(ITER - 1)) begin
            iter_q    <= '0;
            mag_out   <= x_nx;
            angle_out <= zero_q ? '0 : z_nx;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed self-checking bench for cordic_vector.
module tb_cordic_vector;
  import cordic_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] mag_out;
  logic [AW-1:0] angle_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_vector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Accept one vector, wait for the result, complete the output handshake.
  task automatic run_vec(input int x, input int y, output int mag, output int ang,
                         output int lat);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = DW'(x);
    y_in = DW'(y);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
    mag = int'($signed(mag_out));
    ang = int'($signed(angle_out));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
    end
    checks++;
    if (mag_out !== '0) begin
      failures++; $display("FAIL reset_mag got=%0d want=0", mag_out);
    end
    checks++;
    if (angle_out !== '0) begin
      failures++; $display("FAIL reset_angle got=%0d want=0", angle_out);
    end
  endtask

  task automatic test_axis();
    int m, a, l;
    run_vec(65536, 0, m, a, l);
    checks++;
    if (l !== 18) begin
      failures++; $display("FAIL axis_latency got=%0d want=18", l);
    end
    checks++;
    if (iabs(a) > 16) begin
      failures++; $display("FAIL axis_angle got=%0d want=0+-16", a);
    end
    checks++;
    if (iabs(m - 107922) > 16) begin
      failures++; $display("FAIL axis_mag got=%0d want=107922+-16", m);
    end
  endtask

  task automatic test_diag();
    int m, a, l;
    run_vec(65536, 65536, m, a, l);
    checks++;
    if (iabs(a - 51472) > 16) begin
      failures++; $display("FAIL diag_angle got=%0d want=51472+-16", a);
    end
    checks++;
    if (iabs(m - 152624) > 24) begin
      failures++; $display("FAIL diag_mag got=%0d want=152624+-24", m);
    end
  endtask

  task automatic test_neg_x();
    int m, a, l;
    run_vec(-65536, 0, m, a, l);
    checks++;
    if (iabs(a - 205887) > 16) begin
      failures++; $display("FAIL negx_angle got=%0d want=205887+-16", a);
    end
    checks++;
    if (iabs(m - 107922) > 16) begin
      failures++; $display("FAIL negx_mag got=%0d want=107922+-16", m);
    end
    run_vec(-65536, -65536, m, a, l);
    checks++;
    if (iabs(a + 154415) > 16) begin
      failures++; $display("FAIL negdiag_angle got=%0d want=-154415+-16", a);
    end
    checks++;
    if (iabs(m - 152624) > 24) begin
      failures++; $display("FAIL negdiag_mag got=%0d want=152624+-24", m);
    end
  endtask

  task automatic test_neg_y_and_zero();
    int m, a, l;
    run_vec(0, -65536, m, a, l);
    checks++;
    if (iabs(a + 102944) > 16) begin
      failures++; $display("FAIL negy_angle got=%0d want=-102944+-16", a);
    end
    run_vec(0, 0, m, a, l);
    checks++;
    if (a !== 0) begin
      failures++; $display("FAIL zero_angle got=%0d want=0", a);
    end
    checks++;
    if (m !== 0) begin
      failures++; $display("FAIL zero_mag got=%0d want=0", m);
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] m0;
    logic [AW-1:0] a0;
    int            wait_cnt;
    bit            seen;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = DW'(65536);
    y_in = DW'(65536);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL stall_timeout got=%0b want=1", out_valid);
    end
    m0 = mag_out;
    a0 = angle_out;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      x_in = DW'(-65536);
      y_in = DW'(12345);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag_out !== m0 || angle_out !== a0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%0b r=%0b m=%0d a=%0d want v=1 r=0 m=%0d a=%0d",
                 k, out_valid, in_ready, mag_out, angle_out, m0, a0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    seen = 1'b0;
    repeat (22) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || mag_out !== m0) begin
      failures++;
      $display("FAIL stall_ignored got spurious=%0b m=%0d want spurious=0 m=%0d", seen, mag_out, m0);
    end
  endtask

  task automatic test_reset_mid();
    int m, a, l;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = DW'(-65536);
    y_in = DW'(-65536);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_out_valid got=%0b want=0", out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle got spurious=%0b r=%0b want spurious=0 r=1", seen, in_ready);
    end
    run_vec(65536, 0, m, a, l);
    checks++;
    if (l !== 18 || iabs(a) > 16 || iabs(m - 107922) > 16) begin
      failures++;
      $display("FAIL abort_rerun got lat=%0d a=%0d m=%0d want lat=18 a=0+-16 m=107922+-16",
               l, a, m);
    end
  endtask

  initial begin
    test_reset();
    test_axis();
    test_diag();
    test_neg_x();
    test_neg_y_and_zero();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
